// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Decides stalls, flushes and data-memory freezes, and counts them.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_is_jump,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_wr_addr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        WAIT1 = 1'b1
    } state_t;

    // Which single action the pipe takes this cycle.
    typedef enum logic [2:0] {
        M_RESET,
        M_FREEZE,
        M_STALL,
        M_FLOW
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state_q;
    state_t      state_d;
    mode_t       mode;
    logic        match_e;
    logic        match_m;
    logic        haz_two;
    logic        haz_one;
    logic [1:0]  haz_n;
    logic        ctl_flush;

    // Producer/consumer register matches; $0 never hazards.
    always_comb begin
        match_e = ex_reg_write && (ex_wr_addr != 5'd0) &&
                  ((id_uses_rs && (ex_wr_addr == id_rs)) ||
                   (id_uses_rt && (ex_wr_addr == id_rt)));
        match_m = mem_reg_write && (mem_wr_addr != 5'd0) &&
                  ((id_uses_rs && (mem_wr_addr == id_rs)) ||
                   (id_uses_rt && (mem_wr_addr == id_rt)));
    end

    // Stall length needed before forwarding can cover the ID operands.
    always_comb begin
        haz_two = id_is_branch && match_e && ex_mem_read;
        haz_one = (id_is_branch && match_e && !ex_mem_read) ||
                  (id_is_branch && match_m && mem_mem_read) ||
                  (!id_is_branch && match_e && ex_mem_read);
        if (haz_two) begin
            haz_n = 2'd2;
        end else if (haz_one) begin
            haz_n = 2'd1;
        end else begin
            haz_n = 2'd0;
        end
        ctl_flush = (id_is_branch && id_branch_taken) || id_is_jump;
    end

    // Priority: reset, then memory freeze, then data stall, then flow.
    always_comb begin
        if (reset) begin
            mode = M_RESET;
        end else if (mem_wait) begin
            mode = M_FREEZE;
        end else if ((state_q == WAIT1) || (haz_n != 2'd0)) begin
            mode = M_STALL;
        end else begin
            mode = M_FLOW;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        stalling    = 1'b0;
        unique case (mode)
            M_RESET: begin
                state_d = RUN;
            end
            M_FREEZE: begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            M_STALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stalling    = 1'b1;
                if ((state_q == RUN) && (haz_n == 2'd2)) begin
                    state_d = WAIT1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                if_id_flush = ctl_flush;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating stall and flush counters; freeze cycles hold them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stalling && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (if_id_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (CNT_W=4 build).
// Each scenario task drives vectors and checks hand-computed values.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_branch;
    logic             id_branch_taken;
    logic             id_is_jump;
    logic [4:0]       ex_wr_addr;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       mem_wr_addr;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_wait;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic             stalling;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int passed = 0;
    int total  = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, stalling}
    logic [5:0] ctl;
    assign ctl = {pc_write, if_id_write, if_id_flush,
                  id_ex_flush, pipe_freeze, stalling};

    localparam logic [5:0] RUNO   = 6'b110000;
    localparam logic [5:0] STALL  = 6'b000101;
    localparam logic [5:0] FLUSH  = 6'b111000;
    localparam logic [5:0] FREEZE = 6'b000010;

    hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_branch    (id_is_branch),
        .id_branch_taken (id_branch_taken),
        .id_is_jump      (id_is_jump),
        .ex_wr_addr      (ex_wr_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .mem_wr_addr     (mem_wr_addr),
        .mem_reg_write   (mem_reg_write),
        .mem_mem_read    (mem_mem_read),
        .mem_wait        (mem_wait),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .pipe_freeze     (pipe_freeze),
        .stalling        (stalling),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0;
        id_is_jump = 1'b0;
        ex_wr_addr = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_wr_addr = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        mem_wait = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // lw $9 in EX, beq $9,$0 in ID (taken): a 2-cycle hazard.
    task automatic drive_load_branch();
        clear_inputs();
        ex_wr_addr = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd9; id_rt = 5'd0;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        id_is_branch = 1'b1; id_branch_taken = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        ex_wr_addr = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd8; id_uses_rs = 1'b1; id_is_jump = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO) $display("FAIL reset_ctl got=%b exp=%b", ctl, RUNO);
        else passed++;
        next_cycle();
        total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     stall_cycles, flush_count);
        else passed++;
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_wr_addr = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        total++;
        if (ctl !== STALL) $display("FAIL lu_stall got=%b exp=%b", ctl, STALL);
        else passed++;
        next_cycle();
        // Load now in MEM: forwarding covers a non-branch consumer.
        ex_wr_addr = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_wr_addr = 5'd8; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO) $display("FAIL lu_resume got=%b exp=%b", ctl, RUNO);
        else passed++;
        total++;
        if (stall_cycles !== 4'd1)
            $display("FAIL lu_count got=%0d exp=1", stall_cycles);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_load_branch();
        do_reset();
        drive_load_branch();
        #1;
        total++;
        if (ctl !== STALL) $display("FAIL lb_s1 got=%b exp=%b", ctl, STALL);
        else passed++;
        next_cycle();
        // WAIT1 stalls regardless of the inputs.
        clear_inputs();
        id_rs = 5'd9; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        id_is_branch = 1'b1; id_branch_taken = 1'b1;
        #1;
        total++;
        if (ctl !== STALL) $display("FAIL lb_s2 got=%b exp=%b", ctl, STALL);
        else passed++;
        next_cycle();
        total++;
        if (ctl !== FLUSH) $display("FAIL lb_flush got=%b exp=%b", ctl, FLUSH);
        else passed++;
        total++;
        if (stall_cycles !== 4'd2)
            $display("FAIL lb_stalls got=%0d exp=2", stall_cycles);
        else passed++;
        next_cycle();
        clear_inputs();
        #1;
        total++;
        if (flush_count !== 4'd1 || ctl !== RUNO)
            $display("FAIL lb_after got=%0d,%b exp=1,%b",
                     flush_count, ctl, RUNO);
        else passed++;
    endtask

    task automatic test_alu_branch();
        do_reset();
        ex_wr_addr = 5'd5; ex_reg_write = 1'b1;
        id_rs = 5'd5; id_rt = 5'd6;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_is_branch = 1'b1;
        #1;
        total++;
        if (ctl !== STALL) $display("FAIL ab_stall got=%b exp=%b", ctl, STALL);
        else passed++;
        next_cycle();
        ex_reg_write = 1'b0; ex_wr_addr = 5'd0;
        mem_wr_addr = 5'd5; mem_reg_write = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO || stall_cycles !== 4'd1)
            $display("FAIL ab_resume got=%b,%0d exp=%b,1",
                     ctl, stall_cycles, RUNO);
        else passed++;
        next_cycle();
        clear_inputs();
        ex_wr_addr = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd0; id_uses_rs = 1'b1; id_is_branch = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO) $display("FAIL ab_r0 got=%b exp=%b", ctl, RUNO);
        else passed++;
        next_cycle();
        total++;
        if (stall_cycles !== 4'd1)
            $display("FAIL ab_r0cnt got=%0d exp=1", stall_cycles);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive_load_branch();
        next_cycle();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== FREEZE || stall_cycles !== 4'd1)
                $display("FAIL mw_hold%0d got=%b,%0d exp=%b,1",
                         i, ctl, stall_cycles, FREEZE);
            else passed++;
            next_cycle();
        end
        mem_wait = 1'b0;
        #1;
        total++;
        if (ctl !== STALL || stall_cycles !== 4'd1)
            $display("FAIL mw_resume got=%b,%0d exp=%b,1",
                     ctl, stall_cycles, STALL);
        else passed++;
        next_cycle();
        clear_inputs();
        #1;
        total++;
        if (ctl !== RUNO || stall_cycles !== 4'd2)
            $display("FAIL mw_run got=%b,%0d exp=%b,2",
                     ctl, stall_cycles, RUNO);
        else passed++;
    endtask

    task automatic test_reset_in_wait1();
        do_reset();
        drive_load_branch();
        next_cycle();
        reset = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO) $display("FAIL rw_during got=%b exp=%b", ctl, RUNO);
        else passed++;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        total++;
        if (ctl !== RUNO || stall_cycles !== 4'd0)
            $display("FAIL rw_after got=%b,%0d exp=%b,0",
                     ctl, stall_cycles, RUNO);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_wr_addr = 5'd5; ex_reg_write = 1'b1;
        id_rs = 5'd5; id_uses_rs = 1'b1; id_is_branch = 1'b1;
        id_branch_taken = 1'b1;
        for (int i = 0; i < 21; i++) begin
            #1;
            total++;
            if (ctl !== STALL)
                $display("FAIL sat_stall%0d got=%b exp=%b", i, ctl, STALL);
            else passed++;
            next_cycle();
        end
        total++;
        if (stall_cycles !== 4'd15)
            $display("FAIL sat_stalls got=%0d exp=15", stall_cycles);
        else passed++;
        clear_inputs();
        id_is_jump = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            total++;
            if (ctl !== FLUSH)
                $display("FAIL sat_jump%0d got=%b exp=%b", i, ctl, FLUSH);
            else passed++;
            next_cycle();
        end
        total++;
        if (flush_count !== 4'd15 || stall_cycles !== 4'd15)
            $display("FAIL sat_flush got=%0d,%0d exp=15,15",
                     flush_count, stall_cycles);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_mem_wait();
        test_reset_in_wait1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
